st_dma_arbiter: RTL and testbench
=================================

# st_dma_arbiter

Bus-master arbiter between the 68000 bus wrapper and the on-board DMA masters (ACSI/FDC DMA, blitter). It collects requests from N_REQ requesters and runs the 68000 BR/BG/BGACK handshake against the CPU wrapper. It then grants the bus to exactly one requester at a time, and hands the bus back to the CPU, or directly to the next requester, when the owner finishes. All state advances on the CPU phi2 enable, so the arbiter is cycle-aligned with the CPU bus state machine.

## Interface
- N_REQ, default 2: number of DMA requesters; index 0 has highest priority.
- HANDOVER, default 1: when 1, the bus passes from owner to next requester without releasing BGACK; when 0, the bus always returns to the CPU between tenures.

Ports:
- clk: input, 1 bit. System clock.
- reset: input, 1 bit. Reset, synchronous, active-high; clock clk.
- phi1: input, 1 bit. CPU phase-1 clock enable, one clk wide. Used only for sampling.
- phi2: input, 1 bit. CPU phase-2 clock enable, one clk wide. All state changes happen here.
- req: input, N_REQ bits. Level requests; a requester holds its bit high for its whole tenure.
- gnt: output, N_REQ bits. One-hot or zero grant.
- br_n: output, 1 bit. Bus request to the CPU wrapper.
- bg_n: input, 1 bit. Bus grant from the CPU wrapper.
- bgack_n: output, 1 bit. Bus grant acknowledge to the CPU wrapper.
- as_n: input, 1 bit. Bus address strobe (CPU or DMA).
- busy: output, 1 bit. High in any state other than IDLE.

## Operation
- Reset values: br_n=1, bgack_n=1, gnt=0, busy=0, state=IDLE, owner=0. Reset mid-tenure drops everything in the same cycle.
- bg_n and as_n are registered on phi1 (bg_s, as_s). Decisions use the registered copies only.
- FSM states and transitions, evaluated on phi2:
  - IDLE: if |req, go to REQ and set br_n=0.
  - REQ: if !bg_s && as_s, go to ACK. Set bgack_n=0 and br_n=1, latch the priority winner of the current req into owner, and set gnt=onehot(owner).
  - REQ, request withdrawn: if req goes 0 while in REQ, the arbiter still waits for the grant. It never drops br_n before BGACK, because the wrapper would deadlock.
  - ACK, empty grant: if req was 0 when ACK was entered, gnt stays 0. The arbiter holds bgack_n=0 for one phi2, then goes to REL.
  - ACK, normal: after one phi2, go to OWN.
  - OWN: stay while req[owner]=1. When req[owner]=0 and as_s=1, set gnt=0 and go to REL.
  - OWN, strobe still active: if req[owner] falls while as_s=0, gnt stays asserted until as_s=1.
  - REL, handover: if HANDOVER=1 and |req, latch the new winner, set gnt, and go to ACK with bgack_n held 0.
  - REL, return to CPU: otherwise set bgack_n=1 and go to IDLE.
- Priority is fixed: the lowest set index wins, and the winner is evaluated only at the latch points.
- A higher-priority request never pre-empts the current owner.
- gnt is never more than one-hot. gnt is 0 in IDLE, REQ and REL.

## Timing
- Latency from req rising to br_n falling: the next phi2 edge, i.e. ≤1 phi period.
- br_n falls in the same clk as the IDLE→REQ transition.
- gnt rises in the same clk that bgack_n falls.
- Minimum tenure is 2 phi2 (ACK plus one OWN).
- Release: gnt falls on the first phi2 where req[owner]=0 and as_s=1.
  - Return to CPU: bgack_n rises one phi2 later.
  - Handover: there is exactly one phi2 with gnt=0 between owners.
- br_n and bgack_n are never both 0 for more than the single ACK-entry clk. br_n is released in the same clk bgack_n asserts.
- Clocks with neither phi1 nor phi2 high hold all state.

## Structure
- Shared package st_bus_pkg holds:
  - the state encoding (IDLE, REQ, ACK, OWN, REL), as a 3-bit localparam set;
  - the priority-encode function, lowest-set-bit to one-hot.
- One sub-module is natural: st_prio_enc, a parameterized N_REQ one-hot priority encoder, reused by the MMU refresh scheduler.
- The FSM and synchronizer registers stay in this module.

## Test plan
- req=2'b01 and the wrapper model grants 2 phi later:
  - br_n falls at the first phi2;
  - gnt=01 and bgack_n=0 on the phi2 after bg_s=0;
  - after req drops with as_n=1, gnt=0 and then bgack_n=1 one phi2 later;
  - final state IDLE.
- req=2'b11 simultaneously: gnt=01 first. When req[0] drops with HANDOVER=1, gnt=00 for one phi2, then 10, with bgack_n low throughout.
- Same stimulus with HANDOVER=0: bgack_n rises between tenures. br_n re-asserts, and gnt=10 only after a new bg_n.
- req pulses 1 then 0 before bg_n: br_n stays 0 until the grant, then bgack_n=0 for one phi2 with gnt=0, then return to IDLE.
- Owner drops req while as_n=0 for 3 phi: gnt holds 3 more phi2, then falls. Also assert reset during OWN: br_n=1, bgack_n=1 and gnt=0 in the next clk.

Source files
------------

// File: rtl/st_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : st_bus_pkg
//  Description : Shared definitions for the bus-master arbitration logic.
//                Holds the arbiter state encoding and the lowest-set-bit
//                priority function used by st_prio_enc.
//  Revision    : 1.0  initial release
// ============================================================================
package st_bus_pkg;

    // Widest request vector the priority function handles.
    localparam int PRIO_W = 32;

    // Arbiter state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ACK  = 3'd2;
    localparam logic [2:0] ST_OWN  = 3'd3;
    localparam logic [2:0] ST_REL  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_ACK  = ST_ACK,
        S_OWN  = ST_OWN,
        S_REL  = ST_REL
    } arb_state_e;

    // Isolate the lowest set bit: v & -v. Zero in gives zero out.
    function automatic logic [PRIO_W-1:0] prio_onehot(input logic [PRIO_W-1:0] v);
        return v & (~v + PRIO_W'(1));
    endfunction

endpackage : st_bus_pkg
`default_nettype wire

// File: rtl/st_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : st_prio_enc
//  Description : Fixed-priority encoder, index 0 highest priority.
//                Produces the one-hot winner, its binary index and an
//                any-request flag. N must not exceed st_bus_pkg::PRIO_W.
//  Ports       : i_req     - request vector
//                o_onehot  - one-hot winner (zero when no request)
//                o_idx     - binary index of the winner (zero when none)
//                o_any     - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module st_prio_enc
    import st_bus_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [PRIO_W-1:0] w_req_ext;
    logic [PRIO_W-1:0] w_oh_ext;

    generate
        if (N == PRIO_W) begin : g_full
            assign w_req_ext = i_req;
        end else begin : g_pad
            assign w_req_ext = {{(PRIO_W-N){1'b0}}, i_req};
        end
    endgenerate

    assign w_oh_ext = prio_onehot(w_req_ext);
    assign o_onehot = w_oh_ext[N-1:0];
    assign o_any    = |i_req;

    // Upper bits are zero by construction; sink them explicitly.
    generate
        if (N < PRIO_W) begin : g_sink
            logic w_unused_hi;
            assign w_unused_hi = |w_oh_ext[PRIO_W-1:N];
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_oh_ext[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule : st_prio_enc
`default_nettype wire

// File: rtl/st_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : st_dma_arbiter
//  Description : Bus-master arbiter between the 68000 bus wrapper and the
//                DMA masters. Runs the BR/BG/BGACK handshake, grants the bus
//                to one requester at a time (lowest index wins, no
//                pre-emption) and either hands it straight to the next
//                requester (HANDOVER=1) or returns it to the CPU.
//                bg_n/as_n are sampled on phi1; all state moves on phi2.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                phi1, phi2      - CPU phase enables, one clk wide
//                req  [N_REQ]    - level requests, held for whole tenure
//                gnt  [N_REQ]    - one-hot or zero grant
//                br_n            - bus request to CPU wrapper
//                bg_n            - bus grant from CPU wrapper
//                bgack_n         - bus grant acknowledge to CPU wrapper
//                as_n            - address strobe
//                busy            - arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
module st_dma_arbiter
    import st_bus_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int HANDOVER = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phi1,
    input  logic             phi2,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             br_n,
    input  logic             bg_n,
    output logic             bgack_n,
    input  logic             as_n,
    output logic             busy
);

    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [OWN_W-1:0] r_owner;
    logic [OWN_W-1:0] w_owner_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             r_br_n;
    logic             w_br_n_nxt;
    logic             r_bgack_n;
    logic             w_bgack_n_nxt;
    logic             r_bg_s;
    logic             r_as_s;

    logic [N_REQ-1:0] w_win_oh;
    logic [OWN_W-1:0] w_win_idx;
    logic             w_any;
    logic             w_owner_req;

    st_prio_enc #(
        .N     (N_REQ),
        .IDX_W (OWN_W)
    ) u_prio (
        .i_req    (req),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    assign w_owner_req = req[r_owner];

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_gnt_nxt     = r_gnt;
        w_br_n_nxt    = r_br_n;
        w_bgack_n_nxt = r_bgack_n;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_br_n_nxt  = 1'b0;
                end
            end
            // Once BR is out we must wait for the grant even if the request
            // disappears; dropping BR early would deadlock the wrapper.
            S_REQ: begin
                if (!r_bg_s && r_as_s) begin
                    w_state_nxt   = S_ACK;
                    w_bgack_n_nxt = 1'b0;
                    w_br_n_nxt    = 1'b1;
                    w_owner_nxt   = w_win_idx;
                    w_gnt_nxt     = w_win_oh;
                end
            end
            // An empty grant (request withdrawn) just holds BGACK one phi2.
            S_ACK: begin
                w_state_nxt = (r_gnt == '0) ? S_REL : S_OWN;
            end
            // Release only between bus cycles, so a running strobe keeps gnt.
            S_OWN: begin
                if (!w_owner_req && r_as_s) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_REL;
                end
            end
            S_REL: begin
                if ((HANDOVER != 0) && w_any) begin
                    w_state_nxt = S_ACK;
                    w_owner_nxt = w_win_idx;
                    w_gnt_nxt   = w_win_oh;
                end else begin
                    w_bgack_n_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_gnt_nxt     = '0;
                w_br_n_nxt    = 1'b1;
                w_bgack_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_br_n    <= 1'b1;
            r_bgack_n <= 1'b1;
            r_bg_s    <= 1'b1;
            r_as_s    <= 1'b1;
        end else begin
            if (phi1) begin
                r_bg_s <= bg_n;
                r_as_s <= as_n;
            end
            if (phi2) begin
                r_state   <= w_state_nxt;
                r_owner   <= w_owner_nxt;
                r_gnt     <= w_gnt_nxt;
                r_br_n    <= w_br_n_nxt;
                r_bgack_n <= w_bgack_n_nxt;
            end
        end
    end

    assign gnt     = r_gnt;
    assign br_n    = r_br_n;
    assign bgack_n = r_bgack_n;
    assign busy    = (r_state != S_IDLE);

endmodule : st_dma_arbiter
`default_nettype wire

// File: tb/tb_st_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_st_dma_arbiter
//  Description : Self-checking bench for st_dma_arbiter. Two instances share
//                stimulus: one with HANDOVER=1, one with HANDOVER=0. Each
//                phi period is checked against a bus-ownership model, plus
//                directed vector tables and a reset-during-tenure sequence.
//                Output tuple compared everywhere: {gnt, br_n, bgack_n, busy}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_st_dma_arbiter;

    localparam int H1 = 1;   // model slot of the HANDOVER=1 instance
    localparam int H0 = 0;   // model slot of the HANDOVER=0 instance

    logic       clk;
    logic       reset;
    logic       phi1;
    logic       phi2;
    logic [1:0] req;
    logic       bg_n;
    logic       as_n;

    logic [1:0] gnt1, gnt0;
    logic       br1, br0, bgack1, bgack0, busy1, busy0;
    logic [4:0] out1, out0;

    int n_checks = 0;
    int n_fail   = 0;

    st_dma_arbiter #(.N_REQ(2), .HANDOVER(1)) u_ho1 (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .req(req),
        .gnt(gnt1), .br_n(br1), .bg_n(bg_n), .bgack_n(bgack1),
        .as_n(as_n), .busy(busy1)
    );

    st_dma_arbiter #(.N_REQ(2), .HANDOVER(0)) u_ho0 (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .req(req),
        .gnt(gnt0), .br_n(br0), .bg_n(bg_n), .bgack_n(bgack0),
        .as_n(as_n), .busy(busy0)
    );

    assign out1 = {gnt1, br1, bgack1, busy1};
    assign out0 = {gnt0, br0, bgack0, busy0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus-ownership model ----------------
    // Who holds the bus is read off br_n/bgack_n; "fresh" marks the first
    // phi2 of a tenure, "rel" the single phi2 after the owner let go.
    logic [1:0] m_gnt     [2];
    logic       m_br_n    [2];
    logic       m_bgack_n [2];
    int         m_owner   [2];
    bit         m_fresh   [2];
    bit         m_rel     [2];

    function automatic int lowest(input logic [1:0] r);
        for (int i = 0; i < 2; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [4:0] model_out(input int k);
        logic busy_m;
        busy_m = !(m_br_n[k] && m_bgack_n[k]);
        return {m_gnt[k], m_br_n[k], m_bgack_n[k], busy_m};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k] = 2'b00; m_br_n[k] = 1'b1; m_bgack_n[k] = 1'b1;
            m_owner[k] = 0; m_fresh[k] = 1'b0; m_rel[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] r,
                              input logic bg, input logic as_);
        int w;
        w = lowest(r);
        if (m_bgack_n[k]) begin
            if (m_br_n[k]) begin
                if (r != 2'b00) m_br_n[k] = 1'b0;
            end else if (!bg && as_) begin
                m_br_n[k] = 1'b1; m_bgack_n[k] = 1'b0;
                m_gnt[k] = (w < 0) ? 2'b00 : 2'(1 << w);
                m_owner[k] = (w < 0) ? 0 : w;
                m_fresh[k] = 1'b1;
            end
        end else if (m_fresh[k]) begin
            m_fresh[k] = 1'b0;
            m_rel[k] = (m_gnt[k] == 2'b00);
        end else if (m_rel[k]) begin
            if (k == H1 && w >= 0) begin
                m_gnt[k] = 2'(1 << w); m_owner[k] = w;
                m_fresh[k] = 1'b1; m_rel[k] = 1'b0;
            end else begin
                m_bgack_n[k] = 1'b1; m_rel[k] = 1'b0;
            end
        end else if (!r[m_owner[k]] && as_) begin
            m_gnt[k] = 2'b00; m_rel[k] = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {gnt,br_n,bgack_n,busy}=%b expected %b @%0t",
                     name, act, exp, $time);
        end
    endtask

    // One phi period: phi1 samples, optional idle clocks, phi2 acts.
    task automatic phi_cycle(input logic [1:0] r, input logic bg,
                             input logic as_, input int gap);
        @(negedge clk);
        req = r; bg_n = bg; as_n = as_; phi1 = 1'b1; phi2 = 1'b0;
        @(negedge clk);
        phi1 = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0;
        model_step(H1, r, bg, as_);
        model_step(H0, r, bg, as_);
        check("model_h1", out1, model_out(H1));
        check("model_h0", out0, model_out(H0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; phi1 = 1'b0; phi2 = 1'b0; req = 2'b00; bg_n = 1'b1; as_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset_h1", out1, 5'b00110);
        check("reset_h0", out0, 5'b00110);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [1:0] req;
        logic       bg_n;
        logic       as_n;
        logic [4:0] exp;   // {gnt, br_n, bgack_n, busy}
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic bg,
                                input logic as_, input logic [4:0] e);
        vec_t v;
        v.req = r; v.bg_n = bg; v.as_n = as_; v.exp = e;
        return v;
    endfunction

    vec_t tab1 [28];
    vec_t tab0 [11];

    logic [1:0] rq;
    logic       rbg;
    logic       ras;

    initial begin
        // HANDOVER=1: single tenure, 11 handover, empty grant, strobe hold.
        tab1 = '{
            mk(2'b01,1,1,5'b00011), mk(2'b01,1,1,5'b00011), mk(2'b01,0,1,5'b01101),
            mk(2'b01,1,1,5'b01101), mk(2'b01,1,0,5'b01101), mk(2'b00,1,1,5'b00101),
            mk(2'b00,1,1,5'b00110),
            mk(2'b11,1,1,5'b00011), mk(2'b11,0,1,5'b01101), mk(2'b11,1,1,5'b01101),
            mk(2'b10,1,1,5'b00101), mk(2'b10,1,1,5'b10101), mk(2'b10,1,1,5'b10101),
            mk(2'b00,1,1,5'b00101), mk(2'b00,1,1,5'b00110),
            mk(2'b01,1,1,5'b00011), mk(2'b00,1,1,5'b00011), mk(2'b00,0,1,5'b00101),
            mk(2'b00,1,1,5'b00101), mk(2'b00,1,1,5'b00110),
            mk(2'b01,1,1,5'b00011), mk(2'b01,0,1,5'b01101), mk(2'b01,1,0,5'b01101),
            mk(2'b00,1,0,5'b01101), mk(2'b00,1,0,5'b01101), mk(2'b00,1,0,5'b01101),
            mk(2'b00,1,1,5'b00101), mk(2'b00,1,1,5'b00110)
        };
        // HANDOVER=0: bus returns to CPU, new BR/BG round for requester 1.
        tab0 = '{
            mk(2'b11,1,1,5'b00011), mk(2'b11,0,1,5'b01101), mk(2'b11,1,1,5'b01101),
            mk(2'b10,1,1,5'b00101), mk(2'b10,1,1,5'b00110), mk(2'b10,1,1,5'b00011),
            mk(2'b10,1,1,5'b00011), mk(2'b10,0,1,5'b10101), mk(2'b10,1,1,5'b10101),
            mk(2'b00,1,1,5'b00101), mk(2'b00,1,1,5'b00110)
        };

        reset = 1'b1; phi1 = 1'b0; phi2 = 1'b0; req = 2'b00; bg_n = 1'b1; as_n = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();

        for (int i = 0; i < 28; i++) begin
            phi_cycle(tab1[i].req, tab1[i].bg_n, tab1[i].as_n, 0);
            check($sformatf("tab_h1[%0d]", i), out1, tab1[i].exp);
        end

        do_reset();
        for (int i = 0; i < 11; i++) begin
            phi_cycle(tab0[i].req, tab0[i].bg_n, tab0[i].as_n, 0);
            check($sformatf("tab_h0[%0d]", i), out0, tab0[i].exp);
        end

        // Reset in the middle of a tenure, with phi2 active on the same clk.
        do_reset();
        phi_cycle(2'b01, 1'b1, 1'b1, 0);
        phi_cycle(2'b01, 1'b0, 1'b1, 0);
        phi_cycle(2'b01, 1'b1, 1'b1, 0);
        check("own_before_rst", out1, 5'b01101);
        @(negedge clk);
        reset = 1'b1; phi2 = 1'b1;
        @(negedge clk);
        check("rst_in_own_h1", out1, 5'b00110);
        check("rst_in_own_h0", out0, 5'b00110);
        reset = 1'b0; phi2 = 1'b0;
        model_reset();

        // Randomized traffic against the model, with idle-clock gaps.
        rq = 2'b00;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
            rbg = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            ras = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            phi_cycle(rq, rbg, ras, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_st_dma_arbiter
`default_nettype wire
